// File: rtl/ex_hazard_ctrl.sv
// EX-centred hazard controller: operand forwarding, load-use stall/bubble,
// taken-branch redirect with a two-cycle flush, and saturating event counters.
module ex_hazard_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_valid_i,
  input  logic [2:0]  id_sr1_i,
  input  logic [2:0]  id_sr2_i,
  input  logic        id_use_sr1_i,
  input  logic        id_use_sr2_i,
  input  logic        ex_valid_i,
  input  logic [1:0]  ex_op_i,
  input  logic [2:0]  ex_dr_i,
  input  logic        mem_valid_i,
  input  logic [1:0]  mem_op_i,
  input  logic [2:0]  mem_dr_i,
  input  logic        branch_ex_i,
  input  logic [15:0] branch_addr_ex_i,
  output logic        stall_o,
  output logic        bubble_o,
  output logic        flush_o,
  output logic        pc_load_o,
  output logic [15:0] pc_target_o,
  output logic [1:0]  fwd1_sel_o,
  output logic [1:0]  fwd2_sel_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] flush_cnt_o
);

  localparam logic [1:0] OpBr  = 2'b00;
  localparam logic [1:0] OpAdd = 2'b01;
  localparam logic [1:0] OpLdw = 2'b10;

  localparam logic [1:0] FwdReg = 2'b00;
  localparam logic [1:0] FwdEx  = 2'b01;
  localparam logic [1:0] FwdMem = 2'b10;

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StFlush1 = 2'b01,
    StFlush2 = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        pc_load_q, pc_load_d;
  logic [15:0] pc_target_q, pc_target_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic ex_fwd_ok, mem_fwd_ok;
  logic load_use, branch_take;
  logic stall, bubble, flush;
  logic [1:0] fwd1_sel, fwd2_sel;

  // LDW in EX has no data yet, so only ADD forwards from EX.
  assign ex_fwd_ok  = ex_valid_i && (ex_op_i == OpAdd);
  assign mem_fwd_ok = mem_valid_i && ((mem_op_i == OpAdd) || (mem_op_i == OpLdw));

  assign load_use = id_valid_i && ex_valid_i && (ex_op_i == OpLdw) &&
                    ((id_use_sr1_i && (ex_dr_i == id_sr1_i)) ||
                     (id_use_sr2_i && (ex_dr_i == id_sr2_i)));

  assign branch_take = (state_q == StRun) && branch_ex_i && ex_valid_i && !rst_i;

  always_comb begin
    fwd1_sel = FwdReg;
    fwd2_sel = FwdReg;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    if (!rst_i) begin
      if (id_use_sr1_i && ex_fwd_ok && (ex_dr_i == id_sr1_i)) begin
        fwd1_sel = FwdEx;
      end else if (id_use_sr1_i && mem_fwd_ok && (mem_dr_i == id_sr1_i)) begin
        fwd1_sel = FwdMem;
      end
      if (id_use_sr2_i && ex_fwd_ok && (ex_dr_i == id_sr2_i)) begin
        fwd2_sel = FwdEx;
      end else if (id_use_sr2_i && mem_fwd_ok && (mem_dr_i == id_sr2_i)) begin
        fwd2_sel = FwdMem;
      end
      // A taken branch flushes the dependent ID instruction, so no stall is needed.
      if (state_q == StRun) begin
        stall  = load_use && !branch_take;
        bubble = load_use && !branch_take;
      end else begin
        flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StRun: begin
        if (branch_take) begin
          state_d     = StFlush1;
          pc_load_d   = 1'b1;
          pc_target_d = branch_addr_ex_i;
        end
      end
      StFlush1: state_d = StFlush2;
      StFlush2: state_d = StRun;
      default:  state_d = StRun;
    endcase
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (branch_take && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      pc_load_q   <= 1'b0;
      pc_target_q <= 16'h0000;
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_o     = stall;
  assign bubble_o    = bubble;
  assign flush_o     = flush;
  assign fwd1_sel_o  = fwd1_sel;
  assign fwd2_sel_o  = fwd2_sel;
  assign pc_load_o   = pc_load_q;
  assign pc_target_o = pc_target_q;
  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
